// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM encoding and default sizing constants.
package uart_tx_arbiter_pkg;

   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_LOAD_TIMEOUT = 1023;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Scans from ptr upward (wrapping) and returns a one-hot winner.
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic [NUM_REQ-1:0] reqVec,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               valid
);

   int idx;

   // first set request at or after ptr, wrapping around
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!valid && reqVec[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among requesters.
// Supports per-requester frame lock and a sticky load-timeout flag.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
)(
   input  logic                 clockIN,
   input  logic                 resetIN,
   input  logic [NUM_REQ-1:0]   reqIN,
   input  logic [NUM_REQ-1:0]   lockIN,
   input  logic [8*NUM_REQ-1:0] dataIN,
   output logic [NUM_REQ-1:0]   ackOUT,
   output logic [NUM_REQ-1:0]   grantOUT,
   output logic [7:0]           txDataOUT,
   output logic                 txLoadOUT,
   input  logic                 txReadyIN,
   output logic                 busyOUT,
   output logic                 timeoutOUT
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(LOAD_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(LOAD_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);
   localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

   arbState_t state;
   arbState_t stateNext;

   logic [NUM_REQ-1:0] grantNext;
   logic [NUM_REQ-1:0] ackNext;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] winner;
   logic [7:0]         dataNext;
   logic [7:0]         winData;
   logic               loadNext;
   logic               timeoutNext;
   logic               winValid;
   logic               locked;
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ptrNext;
   logic [PW-1:0]      winIdx;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cntNext;

   // a locked owner is the only requester allowed to win
   assign locked   = |(grantOUT & lockIN);
   assign eligible = locked ? (reqIN & grantOUT) : reqIN;
   assign busyOUT  = (state != IDLE);

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) uPick (
      .reqVec (eligible),
      .ptr    (ptr),
      .winner (winner),
      .valid  (winValid)
   );

   // encode the one-hot winner and select its byte
   always_comb begin
      winIdx  = '0;
      winData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            winIdx  = PW'(i);
            winData = dataIN[8*i +: 8];
         end
      end
   end

   // next-state and next-output logic
   always_comb begin
      stateNext   = state;
      grantNext   = grantOUT;
      ackNext     = '0;
      dataNext    = txDataOUT;
      loadNext    = txLoadOUT;
      ptrNext     = ptr;
      cntNext     = cnt;
      timeoutNext = timeoutOUT;
      unique case (state)
         IDLE: begin
            loadNext = 1'b0;
            if (!locked) begin
               grantNext = '0;
            end
            if (txReadyIN && winValid) begin
               stateNext = LOAD;
               grantNext = winner;
               dataNext  = winData;
               loadNext  = 1'b1;
               cntNext   = '0;
               ptrNext   = (winIdx == IDX_LAST) ? '0 : winIdx + 1'b1;
            end
         end
         LOAD: begin
            if (!txReadyIN) begin
               stateNext = DRAIN;
               loadNext  = 1'b0;
               ackNext   = grantOUT;
            end else if (cnt == CNT_LAST) begin
               stateNext   = IDLE;
               loadNext    = 1'b0;
               timeoutNext = 1'b1;
               grantNext   = '0;
            end else if (cnt != CNT_MAX) begin
               cntNext = cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (txReadyIN) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clockIN) begin
      if (resetIN) begin
         state      <= IDLE;
         grantOUT   <= '0;
         ackOUT     <= '0;
         txDataOUT  <= 8'h00;
         txLoadOUT  <= 1'b0;
         ptr        <= '0;
         cnt        <= '0;
         timeoutOUT <= 1'b0;
      end else begin
         state      <= stateNext;
         grantOUT   <= grantNext;
         ackOUT     <= ackNext;
         txDataOUT  <= dataNext;
         txLoadOUT  <= loadNext;
         ptr        <= ptrNext;
         cnt        <= cntNext;
         timeoutOUT <= timeoutNext;
      end
   end

endmodule
